// File: rtl/bram_stream_checker.sv
// bram_stream_checker
//   Consumes the BRAM queue read stream (valid/ready) and compares each accepted word
//   against an incrementing expected value. Tracks accepted words, mismatches, and the
//   first mismatch. Drives the LEDs with a heartbeat or, once an error is seen, an error
//   code.
// Ports
//   CLK, RESET_N        clock, synchronous active-low reset
//   in_valid/in_ready   stream handshake; in_data/in_addr are the word and its address
//   clear               synchronous soft restart, same effect as reset
//   err_flag            sticky mismatch flag
//   err_count           saturating mismatch count
//   word_count          accepted-word count (wraps)
//   first_err_*         address, data and expected value of the first mismatch
//   GPIO_LED            heartbeat hb[HB_W-1 -: 8] or {1, first_err_addr[6:0]}
module bram_stream_checker #(
   parameter int unsigned DATA_W      = 21,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned HB_W        = 24,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              in_ready,
   input  logic              clear,
   output logic              err_flag,
   output logic [15:0]       err_count,
   output logic [31:0]       word_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data,
   output logic [DATA_W-1:0] first_err_expected,
   output logic [7:0]        GPIO_LED
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e              state_q, state_d;
   logic                ready_q, ready_d;
   logic [DATA_W-1:0]   exp_q, exp_d;
   logic [HB_W-1:0]     hb_q, hb_d;
   logic                flag_q, flag_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [31:0]         word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0]   fa_q, fa_d;
   logic [DATA_W-1:0]   fd_q, fd_d;
   logic [DATA_W-1:0]   fe_q, fe_d;
   logic [7:0]          led_q, led_d;
   logic                xfer;

   // clear blocks the handshake in the same cycle it is asserted
   assign in_ready = ready_q & ~clear;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      hb_d       = hb_q;
      flag_d     = flag_q;
      err_cnt_d  = err_cnt_q;
      word_cnt_d = word_cnt_q;
      fa_d       = fa_q;
      fd_d       = fd_q;
      fe_d       = fe_q;

      // ready_q is only ever set in StRun, so xfer implies the run state
      if (xfer) begin
         word_cnt_d = word_cnt_q + 32'd1;
         if (in_data == exp_q) begin
            exp_d = exp_q + DATA_W'(1);
            hb_d  = hb_q + HB_W'(1);
         end else begin
            if (err_cnt_q != 16'hFFFF) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
            if (!flag_q) begin
               fa_d = in_addr;
               fd_d = in_data;
               fe_d = exp_q;
            end
            flag_d = 1'b1;
            if (STOP_ON_ERR) begin
               state_d = StHalt;
            end else begin
               // resynchronise to the incoming stream
               exp_d = in_data + DATA_W'(1);
            end
         end
      end

      ready_d = (state_d == StRun);
      led_d   = flag_d ? {1'b1, fa_d[6:0]} : hb_d[HB_W-1 -: 8];
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N || clear) begin
         state_q    <= StRun;
         ready_q    <= 1'b0;
         exp_q      <= '0;
         hb_q       <= '0;
         flag_q     <= 1'b0;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
         fa_q       <= '0;
         fd_q       <= '0;
         fe_q       <= '0;
         led_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         exp_q      <= exp_d;
         hb_q       <= hb_d;
         flag_q     <= flag_d;
         err_cnt_q  <= err_cnt_d;
         word_cnt_q <= word_cnt_d;
         fa_q       <= fa_d;
         fd_q       <= fd_d;
         fe_q       <= fe_d;
         led_q      <= led_d;
      end
   end

   assign err_flag           = flag_q;
   assign err_count          = err_cnt_q;
   assign word_count         = word_cnt_q;
   assign first_err_addr     = fa_q;
   assign first_err_data     = fd_q;
   assign first_err_expected = fe_q;
   assign GPIO_LED           = led_q;

endmodule

// File: tb/tb_bram_stream_checker.sv
// Testbench: three checkers (halt-on-error, resync-on-error, 4-bit data) fed from
// per-instance stream generators, compared every cycle against a behavioural model.
module tb_bram_stream_checker;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        clear;
   logic [2:0]  v;
   logic [20:0] din [3];
   logic [10:0] ain [3];

   wire  [2:0]  rdy;
   wire  [2:0]  flg;
   wire  [15:0] ec  [3];
   wire  [31:0] wc  [3];
   wire  [10:0] fa  [3];
   wire  [7:0]  led [3];
   wire  [20:0] fd0, fd1, fe0, fe1;
   wire  [3:0]  fd2, fe2;

   always #5 CLK = ~CLK;

   bram_stream_checker #(.DATA_W(21), .ADDR_W(11), .HB_W(24), .STOP_ON_ERR(1'b1)) u_a (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(v[0]), .in_data(din[0]), .in_addr(ain[0]),
      .in_ready(rdy[0]), .clear(clear), .err_flag(flg[0]), .err_count(ec[0]),
      .word_count(wc[0]), .first_err_addr(fa[0]), .first_err_data(fd0),
      .first_err_expected(fe0), .GPIO_LED(led[0]));

   bram_stream_checker #(.DATA_W(21), .ADDR_W(11), .HB_W(24), .STOP_ON_ERR(1'b0)) u_b (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(v[1]), .in_data(din[1]), .in_addr(ain[1]),
      .in_ready(rdy[1]), .clear(clear), .err_flag(flg[1]), .err_count(ec[1]),
      .word_count(wc[1]), .first_err_addr(fa[1]), .first_err_data(fd1),
      .first_err_expected(fe1), .GPIO_LED(led[1]));

   bram_stream_checker #(.DATA_W(4), .ADDR_W(11), .HB_W(24), .STOP_ON_ERR(1'b1)) u_c (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(v[2]), .in_data(din[2][3:0]),
      .in_addr(ain[2]), .in_ready(rdy[2]), .clear(clear), .err_flag(flg[2]),
      .err_count(ec[2]), .word_count(wc[2]), .first_err_addr(fa[2]), .first_err_data(fd2),
      .first_err_expected(fe2), .GPIO_LED(led[2]));

   int n_pass = 0;
   int n_tot  = 0;
   bit started = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   function automatic logic [20:0] get_fd(input int i);
      if (i == 0) return fd0;
      if (i == 1) return fd1;
      return {17'd0, fd2};
   endfunction

   function automatic logic [20:0] get_fe(input int i);
      if (i == 0) return fe0;
      if (i == 1) return fe1;
      return {17'd0, fe2};
   endfunction

   // ---------------- behavioural model ----------------
   int               dw    [3] = '{21, 21, 4};
   bit               stopv [3] = '{1'b1, 1'b0, 1'b1};
   bit               m_ready [3];
   bit               m_halt  [3];
   bit               m_flag  [3];
   longint unsigned  m_exp [3], m_hb [3], m_words [3], m_errs [3];
   longint unsigned  m_fa [3], m_fd [3], m_fe [3];
   longint unsigned  m_x, m_msk;

   initial begin
      forever begin
         @(posedge CLK);
         for (int i = 0; i < 3; i++) begin
            m_msk = (64'd1 << dw[i]) - 64'd1;
            if (!RESET_N || clear) begin
               m_ready[i] = 1'b0; m_halt[i] = 1'b0; m_flag[i] = 1'b0;
               m_exp[i] = 0; m_hb[i] = 0; m_words[i] = 0; m_errs[i] = 0;
               m_fa[i] = 0; m_fd[i] = 0; m_fe[i] = 0;
            end else begin
               if (v[i] && m_ready[i]) begin
                  m_x = longint'(din[i]) & m_msk;
                  m_words[i] = (m_words[i] + 1) % (64'd1 << 32);
                  if (m_x == m_exp[i]) begin
                     m_exp[i] = (m_exp[i] + 1) & m_msk;
                     m_hb[i]++;
                  end else begin
                     if (m_errs[i] < 65535) m_errs[i]++;
                     if (!m_flag[i]) begin
                        m_fa[i] = ain[i]; m_fd[i] = m_x; m_fe[i] = m_exp[i];
                     end
                     m_flag[i] = 1'b1;
                     if (stopv[i]) m_halt[i] = 1'b1;
                     else m_exp[i] = (m_x + 1) & m_msk;
                  end
               end
               m_ready[i] = !m_halt[i];
            end
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge CLK);
         if (started) begin
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("dut%0d in_ready", i), 64'(rdy[i]), 64'(m_ready[i] && !clear));
               chk($sformatf("dut%0d err_flag", i), 64'(flg[i]), 64'(m_flag[i]));
               chk($sformatf("dut%0d err_count", i), 64'(ec[i]), m_errs[i]);
               chk($sformatf("dut%0d word_count", i), 64'(wc[i]), m_words[i]);
               chk($sformatf("dut%0d first_err_addr", i), 64'(fa[i]), m_fa[i]);
               chk($sformatf("dut%0d first_err_data", i), 64'(get_fd(i)), m_fd[i]);
               chk($sformatf("dut%0d first_err_expected", i), 64'(get_fe(i)), m_fe[i]);
               chk($sformatf("dut%0d GPIO_LED", i), 64'(led[i]),
                   m_flag[i] ? (64'h80 | (m_fa[i] & 64'h7F)) : ((m_hb[i] >> 16) & 64'hFF));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int idx [3], lim [3], skip [3];
   bit rnd [3], acc [3];

   task automatic drive_cycle();
      int dv;
      for (int i = 0; i < 3; i++) begin
         if (idx[i] < lim[i] && (!rnd[i] || $urandom_range(0, 1) == 1)) begin
            v[i]   = 1'b1;
            dv     = (idx[i] < skip[i]) ? idx[i] : idx[i] + 1;
            din[i] = 21'(dv);
            ain[i] = 11'(idx[i]);
         end else begin
            v[i]   = 1'b0;
            din[i] = 21'($urandom);
            ain[i] = 11'($urandom);
         end
         acc[i] = v[i] && rdy[i];
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive_cycle();
         @(posedge CLK); #2;
         for (int i = 0; i < 3; i++) if (acc[i]) idx[i]++;
      end
      v = '0;
   endtask

   task automatic set_phase(input int l0, input int l1, input int l2,
                            input int s0, input int s1, input int s2, input bit r1);
      lim = '{l0, l1, l2};
      skip = '{s0, s1, s2};
      rnd = '{1'b0, r1, 1'b0};
      idx = '{0, 0, 0};
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      v = '0;
      repeat (2) begin @(posedge CLK); #2; end
      RESET_N = 1'b1;
      idx = '{0, 0, 0};
   endtask

   task automatic do_clear();
      clear = 1'b1;
      drive_cycle();
      @(posedge CLK); #2;
      clear = 1'b0;
      v = '0;
      idx = '{0, 0, 0};
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s dut%0d in_ready", tag, i), 64'(rdy[i]), 64'd0);
         chk($sformatf("%s dut%0d word_count", tag, i), 64'(wc[i]), 64'd0);
         chk($sformatf("%s dut%0d err_count", tag, i), 64'(ec[i]), 64'd0);
         chk($sformatf("%s dut%0d err_flag", tag, i), 64'(flg[i]), 64'd0);
         chk($sformatf("%s dut%0d first_err_addr", tag, i), 64'(fa[i]), 64'd0);
         chk($sformatf("%s dut%0d GPIO_LED", tag, i), 64'(led[i]), 64'd0);
      end
   endtask

   task automatic check_clean50(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s dut%0d word_count", tag, i), 64'(wc[i]), 64'd50);
         chk($sformatf("%s dut%0d err_count", tag, i), 64'(ec[i]), 64'd0);
         chk($sformatf("%s dut%0d err_flag", tag, i), 64'(flg[i]), 64'd0);
         chk($sformatf("%s dut%0d in_ready", tag, i), 64'(rdy[i]), 64'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0;
      clear   = 1'b0;
      v       = '0;
      for (int i = 0; i < 3; i++) begin din[i] = '0; ain[i] = '0; end
      set_phase(0, 0, 0, 1 << 30, 1 << 30, 1 << 30, 1'b0);
      repeat (3) @(posedge CLK);
      #2;
      RESET_N = 1'b1;
      started = 1'b1;
      check_zero("reset");

      // Gapless 0..4095, randomly gapped 0..999, 4-bit wrap 0..15,0,1
      set_phase(4096, 1000, 18, 1 << 30, 1 << 30, 1 << 30, 1'b1);
      run(4300);
      chk("p1 a word_count", 64'(wc[0]), 64'd4096);
      chk("p1 a err_count", 64'(ec[0]), 64'd0);
      chk("p1 a err_flag", 64'(flg[0]), 64'd0);
      chk("p1 a GPIO_LED", 64'(led[0]), 64'd0);
      chk("p1 b word_count", 64'(wc[1]), 64'd1000);
      chk("p1 b err_count", 64'(ec[1]), 64'd0);
      chk("p1 c word_count", 64'(wc[2]), 64'd18);
      chk("p1 c err_count", 64'(ec[2]), 64'd0);

      // Word 100 replaced by 101 (halt / resync); 4-bit unit corrupts word 5
      do_reset();
      set_phase(200, 200, 30, 100, 100, 5, 1'b0);
      run(250);
      chk("p2 a err_flag", 64'(flg[0]), 64'd1);
      chk("p2 a first_err_expected", 64'(fe0), 64'd100);
      chk("p2 a first_err_data", 64'(fd0), 64'd101);
      chk("p2 a first_err_addr", 64'(fa[0]), 64'd100);
      chk("p2 a in_ready", 64'(rdy[0]), 64'd0);
      chk("p2 a GPIO_LED", 64'(led[0]), 64'hE4);
      chk("p2 a word_count", 64'(wc[0]), 64'd101);
      chk("p2 b err_count", 64'(ec[1]), 64'd1);
      chk("p2 b word_count", 64'(wc[1]), 64'd200);
      chk("p2 b first_err_data", 64'(fd1), 64'd101);
      chk("p2 c first_err_expected", 64'(fe2), 64'd5);
      chk("p2 c first_err_data", 64'(fd2), 64'd6);
      chk("p2 c GPIO_LED", 64'(led[2]), 64'h85);

      // Soft clear after errors, then a clean restart
      do_clear();
      check_zero("clear");
      set_phase(50, 50, 50, 1 << 30, 1 << 30, 1 << 30, 1'b0);
      run(51);
      check_clean50("after clear");

      // Fresh errors, hard reset mid-stream, then a clean restart
      set_phase(30, 30, 30, 10, 10, 10, 1'b0);
      run(20);
      do_reset();
      check_zero("rst");
      set_phase(50, 50, 50, 1 << 30, 1 << 30, 1 << 30, 1'b0);
      run(51);
      check_clean50("after reset");

      @(negedge CLK);
      started = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
